// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and data (D) requesters, D has priority.
// Optional I-side anti-starvation streak limit enabled by defining MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_ack_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic                    d_ack_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    stall_i_o,
  output logic                    stall_d_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t                  r_state;
  logic                    r_owner_d;
  logic                    r_req;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_be;
  logic                    w_idle;
  logic                    w_fair;
  logic                    w_grant_i;
  logic                    w_grant_d;
  logic                    w_done;

  assign w_idle    = r_state == S_IDLE;
  assign w_grant_i = w_idle & i_req_i & (~d_req_i | w_fair);
  assign w_grant_d = w_idle & d_req_i & ~w_grant_i;
  assign w_done    = (r_state == S_WAIT) & mem_rvalid_i;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  logic [SW-1:0] r_streak;
  assign w_fair = r_streak == SW'(MAX_D_STREAK);
  // Counts D grants that overtook a waiting fetch; any I grant or uncontested D grant resets it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_streak <= '0;
    else if (w_grant_i) r_streak <= '0;
    else if (w_grant_d) r_streak <= !i_req_i ? '0 : w_fair ? r_streak : r_streak + 1'b1;
`else
  assign w_fair = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= S_IDLE;
      r_owner_d <= 1'b1;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_grant_i | w_grant_d) begin
            r_state   <= S_REQ;
            r_req     <= 1'b1;
            r_owner_d <= w_grant_d;
            r_we      <= w_grant_d & d_we_i;
            r_addr    <= w_grant_d ? d_addr_i : i_addr_i;
            r_wdata   <= w_grant_d ? d_wdata_i : '0;
            r_be      <= w_grant_d ? d_be_i : '1;
          end
        S_REQ:
          if (mem_gnt_i) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end
        S_WAIT:
          if (mem_rvalid_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end

  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign d_ack_o     = w_done & r_owner_d;
  assign i_ack_o     = w_done & ~r_owner_d;
  assign d_rdata_o   = d_ack_o ? mem_rdata_i : '0;
  assign i_rdata_o   = i_ack_o ? mem_rdata_i : '0;
  assign stall_i_o   = i_req_i & ~i_ack_o;
  assign stall_d_o   = d_req_i & ~d_ack_o;
endmodule
